// File: rtl/pdp8l_iot_pkg.sv
// pdp8l_iot_pkg: shared constants for the PDP-8/L paper tape punch block.
// Holds the punch IOT opcodes, the ident word and the ARM register bit layout.
package pdp8l_iot_pkg;

  // punch IOT opcodes (device 02)
  localparam logic [11:0] IOT_PSF = 12'o6021;
  localparam logic [11:0] IOT_PCF = 12'o6022;
  localparam logic [11:0] IOT_PPC = 12'o6024;
  localparam logic [11:0] IOT_PLS = 12'o6026;

  // 'PP', sizecode 0, version 1
  localparam logic [31:0] PTP_IDENT = 32'h5050_0001;

  // status word (read address 1)
  localparam int RD_NONEMPTY  = 31;
  localparam int RD_ENABLE    = 30;
  localparam int RD_OVFLO     = 29;
  localparam int RD_PNFLAG    = 28;
  localparam int RD_COUNT_LSB = 24;
  localparam int RD_HEAD_LSB  = 0;

  // control word (write address 1)
  localparam int WR_POP       = 31;
  localparam int WR_ENABLE    = 30;
  localparam int WR_CLR_OVFLO = 29;

  typedef enum logic [2:0] {
    IOT_NONE,
    IOT_SKIP_FLAG,
    IOT_CLEAR_FLAG,
    IOT_PUNCH,
    IOT_LOAD_PUNCH
  } iot_e;

  function automatic iot_e decode_iot(input logic [11:0] op);
    case (op)
      IOT_PSF: return IOT_SKIP_FLAG;
      IOT_PCF: return IOT_CLEAR_FLAG;
      IOT_PPC: return IOT_PUNCH;
      IOT_PLS: return IOT_LOAD_PUNCH;
      default: return IOT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pdp8l_ptp_fifo.sv
// pdp8l_ptp_fifo: small character queue between the CPU punch IOTs and the ARM.
// Simultaneous push and pop are allowed; a push into a full queue only lands
// when a pop frees a slot in the same cycle.
module pdp8l_ptp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // character storage; contents need no reset because count gates visibility
  always_ff @(posedge CLOCK) begin
    if (!RESET && push_ok) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally at the power-of-2 depth; count moves only on net change
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pdp8l_ptp_punch.sv
// pdp8l_ptp_punch: PDP-8/L paper tape punch interface.
// Decodes the punch IOTs, queues punched characters for the ARM and drives
// flag/skip/interrupt back to the CPU.
// Optional feature: define PDP8L_PTP_RATELIM_EN to add a 16-bit punch rate
// register that stretches busy after each push.
module pdp8l_ptp_punch
  import pdp8l_iot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        BINIT,
  input  logic        armwrite,
  input  logic        armraddr,
  input  logic        armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        iopstart,
  input  logic        iopstop,
  input  logic [11:0] ioopcode,
  input  logic [11:0] cputodev,
  output logic        IO_SKIP,
  output logic        INT_RQST
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            enable;
  logic            ovflo;
  logic            pnflag;
  logic            busy;
  logic            intenab;
  iot_e            iot;
  logic            iop_go;
  logic            arm_wr1;
  logic            arm_pop;
  logic            push_req;
  logic [7:0]      head;
  logic [CNTW-1:0] count;
  logic [4:0]      count_x;
  logic            full;
  logic            empty;
  logic            unused_bits;
`ifdef PDP8L_PTP_RATELIM_EN
  logic [15:0]     rate;
  logic [15:0]     busy_cnt;
`endif

  assign iot      = decode_iot(ioopcode);
  assign iop_go   = CSTEP & iopstart & enable & ~BINIT;
  assign arm_wr1  = armwrite & armwaddr & ~BINIT;
  assign arm_pop  = arm_wr1 & armwdata[WR_POP];
  assign push_req = iop_go & ((iot == IOT_PUNCH) | (iot == IOT_LOAD_PUNCH));
  assign INT_RQST = intenab & pnflag;
  assign count_x  = 5'(count);
  assign unused_bits = ^{armwdata[28:0], cputodev[11:8]};

  pdp8l_ptp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .push  (push_req),
    .pop   (arm_pop),
    .din   (cputodev[7:0]),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // ARM read mux: ident at address 0, live status and queue head at address 1
  always_comb begin
    armrdata = '0;
    if (!armraddr) begin
      armrdata = PTP_IDENT;
    end else begin
      armrdata[RD_NONEMPTY]         = ~empty;
      armrdata[RD_ENABLE]           = enable;
      armrdata[RD_OVFLO]            = ovflo;
      armrdata[RD_PNFLAG]           = pnflag;
      armrdata[RD_COUNT_LSB +: 4]   = count_x[3:0];
      armrdata[RD_HEAD_LSB +: 8]    = head;
    end
  end

  // control state: ARM register writes, IOT actions, busy timing and the punch flag
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable  <= 1'b0;
      ovflo   <= 1'b0;
      pnflag  <= 1'b0;
      busy    <= 1'b0;
      intenab <= 1'b1;
      IO_SKIP <= 1'b0;
`ifdef PDP8L_PTP_RATELIM_EN
      rate     <= '0;
      busy_cnt <= '0;
`endif
    end else if (BINIT) begin
      pnflag  <= 1'b0;
      busy    <= 1'b0;
      intenab <= 1'b1;
      IO_SKIP <= 1'b0;
`ifdef PDP8L_PTP_RATELIM_EN
      busy_cnt <= '0;
`endif
    end else begin
      if (arm_wr1) begin
        enable <= armwdata[WR_ENABLE];
        if (armwdata[WR_CLR_OVFLO]) ovflo <= 1'b0;
`ifdef PDP8L_PTP_RATELIM_EN
        rate <= armwdata[15:0];
`endif
      end
      // a dropped character wins over a same-cycle overflow clear
      if (push_req && full && !arm_pop) ovflo <= 1'b1;

`ifdef PDP8L_PTP_RATELIM_EN
      // rate 0 and 1 both give the minimum one-cycle busy pulse
      if (push_req) begin
        busy     <= 1'b1;
        busy_cnt <= rate;
      end else if (busy) begin
        if (busy_cnt <= 16'd1) busy <= 1'b0;
        else                   busy_cnt <= busy_cnt - 16'd1;
      end
`else
      busy <= push_req;
`endif

      // ready-to-punch: idle, room in the queue and the interface enabled
      if (!busy && !pnflag && !full && enable) pnflag <= 1'b1;

      if (iop_go) begin
        case (iot)
          IOT_SKIP_FLAG:  IO_SKIP <= pnflag;
          IOT_CLEAR_FLAG: pnflag  <= 1'b0;
          IOT_LOAD_PUNCH: pnflag  <= 1'b0;
          default:        ;
        endcase
      end
      if (CSTEP && iopstop && !iopstart) IO_SKIP <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdp8l_ptp_punch.sv
// tb_pdp8l_ptp_punch: directed bench for the paper tape punch interface with a
// queue-based reference model checked every cycle, plus hand-computed literals.
module tb_pdp8l_ptp_punch;

  localparam int DEPTH = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        CSTEP = 1'b0;
  logic        BINIT = 1'b0;
  logic        armwrite = 1'b0;
  logic        armraddr = 1'b1;
  logic        armwaddr = 1'b1;
  logic [31:0] armwdata = '0;
  logic [31:0] armrdata;
  logic        iopstart = 1'b0;
  logic        iopstop = 1'b0;
  logic [11:0] ioopcode = '0;
  logic [11:0] cputodev = '0;
  logic        IO_SKIP;
  logic        INT_RQST;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  pdp8l_ptp_punch #(.DEPTH(DEPTH)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .CSTEP    (CSTEP),
    .BINIT    (BINIT),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .iopstart (iopstart),
    .iopstop  (iopstop),
    .ioopcode (ioopcode),
    .cputodev (cputodev),
    .IO_SKIP  (IO_SKIP),
    .INT_RQST (INT_RQST)
  );

  always #5 CLOCK = ~CLOCK;

  // reference model state
  logic [7:0] mq[$];
  bit m_en, m_ov, m_pf, m_int, m_skip;
  int m_busy;
  int m_rate;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    if (!armraddr) return 32'h5050_0001;
    w[31] = (mq.size() != 0);
    w[30] = m_en;
    w[29] = m_ov;
    w[28] = m_pf;
    w[27:24] = 4'(mq.size());
    if (mq.size() != 0) w[7:0] = mq[0];
    return w;
  endfunction

  task automatic model_step();
    bit go, wr, push, setflag, new_pf, drop;
    if (RESET) begin
      mq.delete();
      m_en = 0; m_ov = 0; m_pf = 0; m_busy = 0; m_skip = 0; m_int = 1; m_rate = 0;
      return;
    end
    if (BINIT) begin
      m_pf = 0; m_busy = 0; m_skip = 0; m_int = 1;
      return;
    end
    go      = CSTEP && iopstart && m_en;
    wr      = armwrite && armwaddr;
    push    = go && (ioopcode == 12'o6024 || ioopcode == 12'o6026);
    setflag = (m_busy == 0) && !m_pf && (mq.size() < DEPTH) && m_en;
    new_pf  = m_pf | setflag;
    if (go && (ioopcode == 12'o6022 || ioopcode == 12'o6026)) new_pf = 0;
    if (go && ioopcode == 12'o6021) m_skip = m_pf;
    else if (CSTEP && iopstop && !iopstart) m_skip = 0;
    if (wr && armwdata[31] && mq.size() > 0) void'(mq.pop_front());
    drop = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(cputodev[7:0]);
      else drop = 1;
    end
    if (push) begin
`ifdef PDP8L_PTP_RATELIM_EN
      m_busy = (m_rate == 0) ? 1 : m_rate;
`else
      m_busy = 1;
`endif
    end else if (m_busy > 0) m_busy--;
    if (wr) begin
      m_en = armwdata[30];
      if (armwdata[29]) m_ov = 0;
`ifdef PDP8L_PTP_RATELIM_EN
      m_rate = int'(armwdata[15:0]);
`endif
    end
    if (drop) m_ov = 1;
    m_pf = new_pf;
  endtask

  always @(posedge CLOCK) model_step();

  // every-cycle comparison against the model, away from the active edge
  always @(negedge CLOCK) begin
    if (chk_on) begin
      chk("armrdata", armrdata, model_word());
      chk("IO_SKIP", {31'b0, IO_SKIP}, {31'b0, m_skip});
      chk("INT_RQST", {31'b0, INT_RQST}, {31'b0, m_int & m_pf});
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic arm_wr(input logic [31:0] d);
    armwrite = 1; armwaddr = 1; armwdata = d;
    tick();
    armwrite = 0; armwdata = '0;
  endtask

  task automatic iot(input logic [11:0] op, input logic [11:0] ac);
    CSTEP = 1; iopstart = 1; ioopcode = op; cputodev = ac;
    tick();
    CSTEP = 0; iopstart = 0; ioopcode = '0; cputodev = '0;
  endtask

  task automatic iop_end();
    CSTEP = 1; iopstop = 1;
    tick();
    CSTEP = 0; iopstop = 0;
  endtask

  task automatic pop_and_push(input logic [7:0] c);
    armwrite = 1; armwaddr = 1; armwdata = 32'hC000_0000;
    CSTEP = 1; iopstart = 1; ioopcode = 12'o6024; cputodev = {4'b0, c};
    tick();
    armwrite = 0; armwdata = '0;
    CSTEP = 0; iopstart = 0; ioopcode = '0; cputodev = '0;
  endtask

  task automatic wait_flag(output int n);
    n = 0;
    while (armrdata[28] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tick();
    chk_on = 1;
    tick();
    chk("reset status", armrdata, 32'h0000_0000);
    RESET = 0;

    // 1: enable, flag rises two clocks after the write, PSF skip, iopstop drop
    arm_wr(32'h4000_0000);
    chk("enable only", armrdata, 32'h4000_0000);
    tick();
    chk("flag set", armrdata, 32'h5000_0000);
    chk("int rqst", {31'b0, INT_RQST}, 32'd1);
    iot(12'o6021, 12'o0);
    chk("psf skip", {31'b0, IO_SKIP}, 32'd1);
    iop_end();
    chk("iopstop skip", {31'b0, IO_SKIP}, 32'd0);

    // 2: PLS pushes 0301 and clears flag; flag re-sets; pop empties
    iot(12'o6026, 12'o0301);
    chk("pls push", armrdata, 32'hC100_00C1);
    tick();
    tick();
    chk("flag reset after pls", armrdata, 32'hD100_00C1);
    arm_wr(32'hC000_0000);
    chk("pop empty", armrdata, 32'h5000_0000);

    // 3: five PPC pushes into four slots, PPC keeps flag, PCF clears it for good
    for (int i = 1; i <= 5; i++) iot(12'o6024, 12'(i));
    chk("overflow", armrdata, 32'hF400_0001);
    iot(12'o6022, 12'o0);
    chk("pcf", armrdata, 32'hE400_0001);
    repeat (3) tick();
    chk("flag held low when full", armrdata, 32'hE400_0001);
    for (int i = 1; i <= 4; i++) begin
      chk("drain head", {24'b0, armrdata[7:0]}, 32'(i));
      arm_wr(32'hE000_0000 & 32'hC000_0000);
    end
    chk("drain count", {28'b0, armrdata[27:24]}, 32'd0);
    chk("drain nonempty", {31'b0, armrdata[31]}, 32'd0);

    // 4: full queue, same-cycle pop and push
    arm_wr(32'h6000_0000);
    for (int i = 0; i < 4; i++) iot(12'o6024, 12'h010 + 12'(i));
    pop_and_push(8'h55);
    chk("pop+push full", armrdata, 32'hD400_0011);
    chk("pop head 1", {24'b0, armrdata[7:0]}, 32'h11);
    arm_wr(32'hC000_0000);
    chk("pop head 2", {24'b0, armrdata[7:0]}, 32'h12);
    arm_wr(32'hC000_0000);
    chk("pop head 3", {24'b0, armrdata[7:0]}, 32'h13);
    arm_wr(32'hC000_0000);
    chk("last out", {24'b0, armrdata[7:0]}, 32'h55);
    arm_wr(32'hC000_0000);

    // 5: BINIT keeps queue, RESET flushes it; ident read
    iot(12'o6024, 12'h021);
    iot(12'o6024, 12'h022);
    repeat (3) tick();
    BINIT = 1;
    tick();
    BINIT = 0;
    chk("binit", armrdata, 32'hC200_0021);
    chk("binit int", {31'b0, INT_RQST}, 32'd0);
    RESET = 1;
    tick();
    RESET = 0;
    chk("reset flush", armrdata, 32'h0000_0000);
    armraddr = 0;
    #1;
    chk("ident", armrdata, 32'h5050_0001);
    armraddr = 1;

    // disabled: IOPs ignored, flag frozen, pops still work
    arm_wr(32'h4000_0000);
    repeat (2) tick();
    iot(12'o6024, 12'h077);
    repeat (2) tick();
    arm_wr(32'h0000_0000);
    iot(12'o6022, 12'o0);
    iot(12'o6024, 12'h078);
    iot(12'o6021, 12'o0);
    chk("disabled iops", armrdata, 32'h9100_0077);
    chk("disabled skip", {31'b0, IO_SKIP}, 32'd0);
    arm_wr(32'h8000_0000);
    chk("disabled pop", armrdata, 32'h1000_0000);

`ifdef PDP8L_PTP_RATELIM_EN
    // 6: rate-limited busy, restart on a second push
    arm_wr(32'h4000_000A);
    repeat (3) tick();
    iot(12'o6026, 12'h031);
    wait_flag(n);
    chk("rate delay", 32'(n), 32'd11);
    iot(12'o6026, 12'h032);
    repeat (4) tick();
    iot(12'o6024, 12'h033);
    wait_flag(n);
    chk("rate restart", 32'(n), 32'd11);
`else
    // default build: flag rises two clocks after a push
    arm_wr(32'h4000_000A);
    repeat (3) tick();
    iot(12'o6026, 12'h031);
    wait_flag(n);
    chk("push to flag", 32'(n), 32'd2);
`endif

    repeat (2) tick();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
